bist_test_sequencer: RTL
========================

// Module: bist_test_sequencer
// PURPOSE
//  Sequences STRAIT self-test. Steps the eNVM pattern store through all SA patterns, then all TD patterns.
//  Hands each pattern to the systolic-array scan path and collects per-PE fail results.
//  Accumulates a sticky fault map, then writes it back into eNVM fault storage, one row per cycle.
//  Sits between the top-level test control, the eNVM and the array scan/compare logic.
// PARAMETERS
//  SYSTOLIC_SIZE          8   array is N x N PEs
//  SA_TEST_PATTERN_DEPTH  12  number of stuck-at patterns
//  TD_TEST_PATTERN_DEPTH  18  number of transition-delay patterns
//  MAX_ADDR_WIDTH         $clog2(max(SA,TD) depth)  pattern index width
//  ADDR_WIDTH             $clog2(SYSTOLIC_SIZE)     row index width
//  TIMEOUT_CYCLES         64  max wait for a result per pattern (>=2)
// PORTS
//  clk                  in   1    clock
//  rst                  in   1    async reset, active-high
//  start                in   1    begin test run (honoured only in IDLE)
//  test_type            out  1    0: SA, 1: TD; drives eNVM pattern select
//  test_counter         out  MAX_ADDR_WIDTH  current pattern index into eNVM
//  scan_valid           out  1    pattern ready for scan-in
//  scan_ready           in   1    scan path accepts pattern
//  result_valid         in   1    array compare result present
//  pe_fail_flat         in   N*N  per-PE mismatch; bit r*N+c = PE(r,c)
//  detection_en         out  1    eNVM write strobe
//  counter              out  ADDR_WIDTH  eNVM row being written
//  single_pe_detection  out  N    fault-map row[counter]
//  row_fault_detection  out  1    &row[counter] (whole row faulty)
//  column_fault_detection out 1   AND over r of map[r][counter] (whole column faulty)
//  busy                 out  1    high in every state except IDLE
//  done                 out  1    one-cycle pulse at end of run
//  fault_found          out  1    sticky: any map bit set; cleared on start
//  timeout_err          out  1    sticky: any pattern timed out; cleared on start
// BEHAVIOUR
//  Reset: state=IDLE; test_type=0; test_counter=0; counter=0; fault map=0; all strobes/flags 0.
//  Reset is legal mid-run: the run aborts and no further eNVM writes occur.
//  FSM states and transitions:
//   - IDLE: start -> ISSUE. Clear map, flags, test_type, test_counter.
//   - ISSUE: scan_valid=1. On scan_valid&scan_ready (same cycle) -> WAIT. result_valid is ignored here.
//   - WAIT: timer restarts from 0 on entry.
//     - result_valid: map |= pe_fail_flat, then go to NEXT.
//     - Otherwise, at timer==TIMEOUT_CYCLES-1: set timeout_err, set map to all ones (fail-safe), go to NEXT.
//   - NEXT: one cycle. Branch in this order:
//     - If test_counter < depth(test_type)-1: increment test_counter, go to ISSUE.
//     - Else if test_type==0: test_type=1, test_counter=0, go to ISSUE.
//     - Else: go to WB.
//   - WB: detection_en=1 for exactly N consecutive cycles, counter=0..N-1, detection outputs combinational from map. Then DONE.
//   - DONE: done=1 for one cycle, then IDLE.
//  test_type and test_counter are stable from ISSUE entry until NEXT; eNVM reads them combinationally.
//  Ignored inputs:
//   - start outside IDLE, including a start in the same cycle as done.
//   - result_valid outside WAIT.
//  fault_found = |map, registered; updates the cycle after a map write.
//  Zero-wait latency (scan_ready and result_valid high on first opportunity):
//   - 3 cycles per pattern (ISSUE, WAIT, NEXT).
//   - start to done: 3*(SA+TD)+N+1 cycles (=99 at defaults).
// STRUCTURE
//  Package strait_test_pkg: state enum {IDLE,ISSUE,WAIT,NEXT,WB,DONE}; SA/TD type constants; pattern-depth lookup function.
//  Sub-module strait_fault_map: N*N sticky register with clear, OR-merge, set-all, and row/column AND reductions indexed by counter.
// TESTING
//  1. Defaults, scan_ready=1, result_valid one cycle after scan handshake, pe_fail=0.
//     -> Pattern order SA 0..11 then TD 0..17.
//     -> 8 WB writes with zero data; done at cycle 99; fault_found=0.
//  2. SA pattern 3 returns PE(2,5) fail only.
//     -> WB row 2 gives single_pe_detection=8'b0010_0000.
//     -> row/column fault = 0; fault_found=1.
//  3. All patterns fail every PE of column 4.
//     -> column_fault_detection=1 at counter 4 only; row_fault_detection=0 for all rows.
//  4. Withhold result_valid for TD pattern 7.
//     -> At the 64th WAIT cycle: timeout_err=1, map all ones.
//     -> Run continues to TD 8; every WB row = 8'hFF, row and column fault = 1.
//  5. scan_ready low for 5 cycles, plus start pulses during WAIT and in the DONE cycle.
//     -> scan_valid held and test_counter stable while ready is low.
//     -> Both start pulses ignored; no second run.
//  6. Assert rst during WB at counter 3.
//     -> detection_en drops immediately; outputs at reset values.
//     -> Next start re-runs from SA 0 with a cleared map.

Source files
------------

// File: rtl/strait_test_pkg.sv
// strait_test_pkg: shared types and helpers for the STRAIT BIST sequencer
//   state_t        sequencer FSM states
//   TYPE_SA/TD     eNVM pattern-type select encodings
//   pattern_depth  number of patterns for a given test type
package strait_test_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, WB, DONE} state_t;

    localparam logic TYPE_SA = 1'b0;
    localparam logic TYPE_TD = 1'b1;

    function automatic int pattern_depth(input logic tt, input int sa_depth, input int td_depth);
        return (tt == TYPE_TD) ? td_depth : sa_depth;
    endfunction

endpackage

// File: rtl/strait_fault_map.sv
// strait_fault_map: sticky N x N per-PE fault map with row/column AND reductions
//   clk, rst     clock, async active-high reset
//   clr          clear whole map (wins over everything)
//   set_all      force every bit to one
//   merge_en     OR merge_data into the map
//   merge_data   bit r*N+c = PE(r,c)
//   idx          row (and column) being reported
//   row          map row idx
//   row_all      whole row idx faulty
//   col_all      whole column idx faulty
//   any          registered OR of the whole map
module strait_fault_map #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            set_all,
    input  logic            merge_en,
    input  logic [N*N-1:0]  merge_data,
    input  logic [AW-1:0]   idx,
    output logic [N-1:0]    row,
    output logic            row_all,
    output logic            col_all,
    output logic            any
);

    logic [N-1:0][N-1:0] map_q, map_d;
    logic                any_q, any_d;
    logic [N-1:0]        col_bits;

    always_comb begin
        map_d = clr ? '0 : set_all ? '1 : merge_en ? (map_q | merge_data) : map_q;
        any_d = |map_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map_q <= '0;
            any_q <= 1'b0;
        end else begin
            map_q <= map_d;
            any_q <= any_d;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_col
        assign col_bits[r] = map_q[r][idx];
    end

    assign row     = map_q[idx];
    assign row_all = &row;
    assign col_all = &col_bits;
    assign any     = any_q;

endmodule

// File: rtl/bist_test_sequencer.sv
// bist_test_sequencer: steps eNVM through all SA then TD patterns, collects per-PE
// fail results into a sticky fault map and writes the map back one row per cycle.
//   clk, rst                async active-high reset
//   start                   begin run (IDLE only)
//   test_type/test_counter  eNVM pattern select and index
//   scan_valid/scan_ready   pattern handshake to the array scan path
//   result_valid/pe_fail_flat  compare result, bit r*N+c = PE(r,c)
//   detection_en, counter   eNVM fault-storage write strobe and row
//   single_pe_detection, row_fault_detection, column_fault_detection  write data
//   busy, done, fault_found, timeout_err  status
module bist_test_sequencer
    import strait_test_pkg::*;
#(
    parameter int SYSTOLIC_SIZE         = 8,
    parameter int SA_TEST_PATTERN_DEPTH = 12,
    parameter int TD_TEST_PATTERN_DEPTH = 18,
    parameter int MAX_ADDR_WIDTH        = $clog2((SA_TEST_PATTERN_DEPTH > TD_TEST_PATTERN_DEPTH) ?
                                                 SA_TEST_PATTERN_DEPTH : TD_TEST_PATTERN_DEPTH),
    parameter int ADDR_WIDTH            = $clog2(SYSTOLIC_SIZE),
    parameter int TIMEOUT_CYCLES        = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 test_type,
    output logic [MAX_ADDR_WIDTH-1:0]            test_counter,
    output logic                                 scan_valid,
    input  logic                                 scan_ready,
    input  logic                                 result_valid,
    input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] pe_fail_flat,
    output logic                                 detection_en,
    output logic [ADDR_WIDTH-1:0]                counter,
    output logic [SYSTOLIC_SIZE-1:0]             single_pe_detection,
    output logic                                 row_fault_detection,
    output logic                                 column_fault_detection,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 fault_found,
    output logic                                 timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t                    state_q, state_d;
    logic                      test_type_q, test_type_d;
    logic [MAX_ADDR_WIDTH-1:0] test_counter_q, test_counter_d;
    logic [ADDR_WIDTH-1:0]     counter_q, counter_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic                      timeout_err_q, timeout_err_d;
    logic                      map_clr, map_merge, map_set;

    always_comb begin
        state_d        = state_q;
        test_type_d    = test_type_q;
        test_counter_d = test_counter_q;
        counter_d      = counter_q;
        timer_d        = timer_q;
        timeout_err_d  = timeout_err_q;
        map_clr        = 1'b0;
        map_merge      = 1'b0;
        map_set        = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d        = ISSUE;
                test_type_d    = TYPE_SA;
                test_counter_d = '0;
                timeout_err_d  = 1'b0;
                map_clr        = 1'b1;
            end
            ISSUE: begin
                // timer is zeroed here so it starts from 0 on WAIT entry
                timer_d = '0;
                if (scan_ready) state_d = WAIT;
            end
            WAIT: begin
                if (result_valid) begin
                    map_merge = 1'b1;
                    state_d   = NEXT;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // a lost result is treated as every PE failing
                    timeout_err_d = 1'b1;
                    map_set       = 1'b1;
                    state_d       = NEXT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            NEXT: begin
                if (int'(test_counter_q) <
                    pattern_depth(test_type_q, SA_TEST_PATTERN_DEPTH, TD_TEST_PATTERN_DEPTH) - 1) begin
                    test_counter_d = test_counter_q + MAX_ADDR_WIDTH'(1);
                    state_d        = ISSUE;
                end else if (test_type_q == TYPE_SA) begin
                    test_type_d    = TYPE_TD;
                    test_counter_d = '0;
                    state_d        = ISSUE;
                end else begin
                    counter_d = '0;
                    state_d   = WB;
                end
            end
            WB: begin
                counter_d = counter_q + ADDR_WIDTH'(1);
                if (counter_q == ADDR_WIDTH'(SYSTOLIC_SIZE - 1)) state_d = DONE;
            end
            DONE: begin
                counter_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            test_type_q    <= TYPE_SA;
            test_counter_q <= '0;
            counter_q      <= '0;
            timer_q        <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            test_type_q    <= test_type_d;
            test_counter_q <= test_counter_d;
            counter_q      <= counter_d;
            timer_q        <= timer_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    strait_fault_map #(
        .N  (SYSTOLIC_SIZE),
        .AW (ADDR_WIDTH)
    ) u_map (
        .clk        (clk),
        .rst        (rst),
        .clr        (map_clr),
        .set_all    (map_set),
        .merge_en   (map_merge),
        .merge_data (pe_fail_flat),
        .idx        (counter_q),
        .row        (single_pe_detection),
        .row_all    (row_fault_detection),
        .col_all    (column_fault_detection),
        .any        (fault_found)
    );

    assign test_type    = test_type_q;
    assign test_counter = test_counter_q;
    assign counter      = counter_q;
    assign scan_valid   = (state_q == ISSUE);
    assign detection_en = (state_q == WB);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign timeout_err  = timeout_err_q;

endmodule
